pwm_seq_ctrl: RTL and testbench
===============================

// Module: pwm_seq_ctrl
// PURPOSE
//  Sequencer for one PWM channel: owns the period counter and steps through a table of
//  {compare1, compare2, function, repeat} entries, holding each for a number of periods.
//  Drives the pwm_gen config inputs so new compare/function values appear exactly when
//  count_val returns to 0. Sits between the CPU register block and pwm_gen.
// PARAMETERS
//  DEPTH   8                     table entries (power of 2, >=2)
//  ADDR_W  $clog2(DEPTH)         table index width
//  ENTRY_W 42                    {func[1:0], rep[7:0], cmp2[15:0], cmp1[15:0]}, MSB first
// PORTS
//  clk        in   1        peripheral clock
//  rst        in   1        synchronous reset, active-high
//  cfg_we     in   1        table write strobe
//  cfg_addr   in   ADDR_W   table write index
//  cfg_wdata  in   ENTRY_W  table write data
//  period_in  in   16       period (last count value), latched at start
//  seq_len    in   ADDR_W+1 entries used (1..DEPTH), latched at start
//  loop_en    in   1        1: wrap to entry 0 after last entry; 0: one-shot
//  start      in   1        start pulse (ignored while busy)
//  stop       in   1        stop request; honoured at the next period boundary
//  pwm_en     out  1        enable to pwm_gen
//  period     out  16       latched period
//  functions  out  8        {6'b0, func} of current entry
//  compare1   out  16       cmp1 of current entry
//  compare2   out  16       cmp2 of current entry
//  count_val  out  16       period counter
//  cur_idx    out  ADDR_W   index of entry currently output
//  busy       out  1        high in RUN
//  seq_done   out  1        one-cycle pulse when a one-shot sequence or stop completes
// BEHAVIOUR
//  - All outputs registered. Reset: every output 0, state IDLE, stop_pend 0; table contents 0.
//  - Table write: cfg_we with cfg_addr<DEPTH writes entry; allowed while busy, seen on the
//    entry's next load. Same-cycle write and load of same index: load sees OLD data.
//  - States IDLE, RUN.
//  - IDLE: start & seq_len in 1..DEPTH -> RUN on same edge: latch period_in/seq_len/loop_en,
//    load entry 0, count_val=0, cur_idx=0, rep_cnt=0, pwm_en=1, busy=1. Else stay;
//    seq_len==0 or >DEPTH -> start ignored.
//  - RUN, count_val<period: count_val+1. At count_val==period (boundary), count_val<=0 and:
//    * stop_pend or stop this cycle -> IDLE, pwm_en=0, busy=0, seq_done=1, count_val=0.
//    * else rep_cnt+1 < max(rep,1) -> rep_cnt+1, same entry.
//    * else rep_cnt=0; cur_idx<seq_len-1 -> cur_idx+1, load entry;
//      last entry & loop_en -> cur_idx=0, load entry 0; last & !loop_en -> IDLE, seq_done=1.
//  - Entry load updates compare1/compare2/functions on the same edge count_val becomes 0.
//  - stop in RUN off-boundary sets stop_pend; cleared on entering IDLE. stop in IDLE: no effect.
//  - start in RUN ignored. rep==0 treated as 1. period==0: every cycle is a boundary.
//  - Counter arithmetic 16-bit unsigned; never exceeds period, no wrap past 16'hFFFF.
//  - Functions, compares, period, cur_idx hold their last values in IDLE.
// STRUCTURE
//  - Package pwm_pkg: state enum, entry field offsets/widths, FUNC_* codes (00,01,10).
//  - Sub-module pwm_seq_mem: DEPTH x ENTRY_W register file, 1 write port, async read port.
//  - Top: FSM, period/repeat counters, stop_pend, output registers.
// TESTING
//  - Reset mid-RUN (rst=1 at count 5) -> next cycle all outputs 0, IDLE; start works after.
//  - period=9, seq_len=2, e0{cmp1=3,rep=2}, e1{cmp1=7,rep=1}, one-shot -> e0 for 20 cycles,
//    e1 for 10, seq_done at cycle 30, pwm_en low after; compare1 changes only with count 0.
//  - Same table, loop_en=1 -> cur_idx 0,0,1,0,0,1... per period; stop at count 4 of e1 ->
//    runs to count 9, then IDLE, seq_done one cycle, busy 0.
//  - period=0, seq_len=3, reps 1 -> cur_idx 0,1,2 on consecutive cycles, count_val stays 0.
//  - rep=0 entry behaves as rep=1; seq_len=0 start -> stays IDLE, busy 0.
//  - Write e1 cmp1=5 while e0 running -> e1 loads 5; write to cfg_addr=DEPTH ignored.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and constants for the PWM sequencer: FSM states, table entry
// layout and the function codes passed through to pwm_gen.
package pwm_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } state_t;

  // Entry layout, MSB first: {func[1:0], rep[7:0], cmp2[15:0], cmp1[15:0]}
  localparam int ENTRY_W  = 42;
  localparam int CMP_W    = 16;
  localparam int REP_W    = 8;
  localparam int FUNC_W   = 2;
  localparam int CMP1_LSB = 0;
  localparam int CMP2_LSB = 16;
  localparam int REP_LSB  = 32;
  localparam int FUNC_LSB = 40;

  // Output modes understood by pwm_gen; the sequencer only forwards them
  localparam logic [FUNC_W-1:0] FUNC_EDGE   = 2'b00;
  localparam logic [FUNC_W-1:0] FUNC_CENTER = 2'b01;
  localparam logic [FUNC_W-1:0] FUNC_DUAL   = 2'b10;

endpackage

// File: rtl/pwm_seq_ctrl_if.sv
// CPU-side configuration/control bus and pwm_gen-side outputs of the sequencer.
interface pwm_seq_ctrl_if #(
  parameter int DEPTH = 8
);
  import pwm_pkg::*;

  localparam int ADDR_W = $clog2(DEPTH);

  logic               cfg_we;
  logic [ADDR_W-1:0]  cfg_addr;
  logic [ENTRY_W-1:0] cfg_wdata;
  logic [15:0]        period_in;
  logic [ADDR_W:0]    seq_len;
  logic               loop_en;
  logic               start;
  logic               stop;

  logic               pwm_en;
  logic [15:0]        period;
  logic [7:0]         functions;
  logic [15:0]        compare1;
  logic [15:0]        compare2;
  logic [15:0]        count_val;
  logic [ADDR_W-1:0]  cur_idx;
  logic               busy;
  logic               seq_done;

  modport master (
    output cfg_we, cfg_addr, cfg_wdata, period_in, seq_len, loop_en, start, stop,
    input  pwm_en, period, functions, compare1, compare2, count_val, cur_idx, busy, seq_done
  );

  modport slave (
    input  cfg_we, cfg_addr, cfg_wdata, period_in, seq_len, loop_en, start, stop,
    output pwm_en, period, functions, compare1, compare2, count_val, cur_idx, busy, seq_done
  );

endinterface

// File: rtl/pwm_seq_mem.sv
// Sequence table: DEPTH x ENTRY_W register file, one write port, async read.
// A read in the same cycle as a write to that entry returns the old contents.
module pwm_seq_mem #(
  parameter int DEPTH   = 8,
  parameter int ENTRY_W = 42,
  parameter int ADDR_W  = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [ENTRY_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [ENTRY_W-1:0] rdata
);

  logic [ENTRY_W-1:0] mem [DEPTH];

  // Clear the table on reset, otherwise accept in-range writes
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else if (we && (int'(waddr) < DEPTH)) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/pwm_seq_ctrl.sv
// PWM channel sequencer: owns the period counter and walks the entry table,
// presenting each entry's compare/function values to pwm_gen exactly when the
// counter returns to 0, holding each entry for max(rep,1) periods.
module pwm_seq_ctrl
  import pwm_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input logic           clk,
  input logic           rst,
  pwm_seq_ctrl_if.slave bus
);

  localparam int ADDR_W = $clog2(DEPTH);
  localparam logic [ADDR_W:0] LEN_MAX = (ADDR_W+1)'(DEPTH);

  state_t             state_q, state_d;
  logic [15:0]        count_q, count_d;
  logic [15:0]        period_q, period_d;
  logic [REP_W-1:0]   rep_cnt_q, rep_cnt_d;
  logic [REP_W-1:0]   rep_q, rep_d;
  logic [ADDR_W-1:0]  idx_q, idx_d;
  logic [ADDR_W:0]    len_q, len_d;
  logic               loop_q, loop_d;
  logic               stop_pend_q, stop_pend_d;
  logic               pwm_en_q, pwm_en_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic [CMP_W-1:0]   cmp1_q, cmp1_d;
  logic [CMP_W-1:0]   cmp2_q, cmp2_d;
  logic [FUNC_W-1:0]  func_q, func_d;

  logic [ADDR_W-1:0]  rd_addr;
  logic [ENTRY_W-1:0] rd_data;
  logic               load_en;
  logic [REP_W:0]     rep_next;
  logic [REP_W:0]     rep_eff;

  pwm_seq_mem #(
    .DEPTH   (DEPTH),
    .ENTRY_W (ENTRY_W)
  ) u_mem (
    .clk   (clk),
    .rst   (rst),
    .we    (bus.cfg_we),
    .waddr (bus.cfg_addr),
    .wdata (bus.cfg_wdata),
    .raddr (rd_addr),
    .rdata (rd_data)
  );

  // A repeat count of 0 is treated as a single period
  assign rep_next = {1'b0, rep_cnt_q} + 1'b1;
  assign rep_eff  = (rep_q == '0) ? (REP_W+1)'(1) : {1'b0, rep_q};

  // Next-state, counter and entry-load decisions
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    period_d    = period_q;
    rep_cnt_d   = rep_cnt_q;
    rep_d       = rep_q;
    idx_d       = idx_q;
    len_d       = len_q;
    loop_d      = loop_q;
    stop_pend_d = stop_pend_q;
    pwm_en_d    = pwm_en_q;
    busy_d      = busy_q;
    done_d      = 1'b0;
    cmp1_d      = cmp1_q;
    cmp2_d      = cmp2_q;
    func_d      = func_q;
    rd_addr     = '0;
    load_en     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (bus.start && (bus.seq_len != '0) && (bus.seq_len <= LEN_MAX)) begin
          state_d     = ST_RUN;
          period_d    = bus.period_in;
          len_d       = bus.seq_len;
          loop_d      = bus.loop_en;
          count_d     = '0;
          idx_d       = '0;
          rep_cnt_d   = '0;
          stop_pend_d = 1'b0;
          pwm_en_d    = 1'b1;
          busy_d      = 1'b1;
          rd_addr     = '0;
          load_en     = 1'b1;
        end
      end

      ST_RUN: begin
        if (count_q < period_q) begin
          count_d = count_q + 16'd1;
          if (bus.stop) begin
            stop_pend_d = 1'b1;
          end
        end else begin
          count_d = '0;
          if (stop_pend_q || bus.stop) begin
            state_d     = ST_IDLE;
            pwm_en_d    = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b1;
            stop_pend_d = 1'b0;
          end else if (rep_next < rep_eff) begin
            rep_cnt_d = rep_next[REP_W-1:0];
          end else begin
            rep_cnt_d = '0;
            if ({1'b0, idx_q} < (len_q - 1'b1)) begin
              idx_d   = idx_q + 1'b1;
              rd_addr = idx_q + 1'b1;
              load_en = 1'b1;
            end else if (loop_q) begin
              idx_d   = '0;
              rd_addr = '0;
              load_en = 1'b1;
            end else begin
              state_d     = ST_IDLE;
              pwm_en_d    = 1'b0;
              busy_d      = 1'b0;
              done_d      = 1'b1;
              stop_pend_d = 1'b0;
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase

    if (load_en) begin
      cmp1_d = rd_data[CMP1_LSB +: CMP_W];
      cmp2_d = rd_data[CMP2_LSB +: CMP_W];
      rep_d  = rd_data[REP_LSB  +: REP_W];
      func_d = rd_data[FUNC_LSB +: FUNC_W];
    end
  end

  // State register and all registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      period_q    <= '0;
      rep_cnt_q   <= '0;
      rep_q       <= '0;
      idx_q       <= '0;
      len_q       <= '0;
      loop_q      <= 1'b0;
      stop_pend_q <= 1'b0;
      pwm_en_q    <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      cmp1_q      <= '0;
      cmp2_q      <= '0;
      func_q      <= '0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      period_q    <= period_d;
      rep_cnt_q   <= rep_cnt_d;
      rep_q       <= rep_d;
      idx_q       <= idx_d;
      len_q       <= len_d;
      loop_q      <= loop_d;
      stop_pend_q <= stop_pend_d;
      pwm_en_q    <= pwm_en_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      cmp1_q      <= cmp1_d;
      cmp2_q      <= cmp2_d;
      func_q      <= func_d;
    end
  end

  assign bus.pwm_en    = pwm_en_q;
  assign bus.period    = period_q;
  assign bus.functions = {6'b0, func_q};
  assign bus.compare1  = cmp1_q;
  assign bus.compare2  = cmp2_q;
  assign bus.count_val = count_q;
  assign bus.cur_idx   = idx_q;
  assign bus.busy      = busy_q;
  assign bus.seq_done  = done_q;

endmodule

// File: tb/tb_pwm_seq_ctrl.sv
// Bench for pwm_seq_ctrl: vector table, hand-written corner sequences and
// randomized runs checked against a schedule-expansion reference model.
module tb_pwm_seq_ctrl;
  import pwm_pkg::*;

  localparam int DEPTH = 8;

  typedef struct packed {
    logic        pwm_en;
    logic        busy;
    logic        seq_done;
    logic [15:0] count;
    logic [2:0]  idx;
    logic [15:0] cmp1;
    logic [15:0] cmp2;
    logic [7:0]  func;
    logic [15:0] period;
  } obs_t;

  typedef struct {
    logic [1:0]  func;
    logic [7:0]  rep;
    logic [15:0] cmp2;
    logic [15:0] cmp1;
  } ent_t;

  typedef struct {
    bit start;
    bit stop;
    int len;
    bit exp_run;
    bit exp_done;
    int exp_idx;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   passed = 0;
  ent_t mdl_tab [DEPTH];

  always #5 clk = ~clk;

  pwm_seq_ctrl_if #(.DEPTH(DEPTH)) bus ();

  pwm_seq_ctrl #(.DEPTH(DEPTH)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  function automatic ent_t mk_ent(int c1, int c2, int rep, int fn);
    ent_t e;
    e.cmp1 = 16'(c1);
    e.cmp2 = 16'(c2);
    e.rep  = 8'(rep);
    e.func = 2'(fn);
    return e;
  endfunction

  function automatic logic [ENTRY_W-1:0] pack(ent_t e);
    return {e.func, e.rep, e.cmp2, e.cmp1};
  endfunction

  function automatic obs_t get_obs();
    obs_t o;
    o.pwm_en   = bus.pwm_en;
    o.busy     = bus.busy;
    o.seq_done = bus.seq_done;
    o.count    = bus.count_val;
    o.idx      = bus.cur_idx;
    o.cmp1     = bus.compare1;
    o.cmp2     = bus.compare2;
    o.func     = bus.functions;
    o.period   = bus.period;
    return o;
  endfunction

  function automatic obs_t mk_exp(bit run, bit done, int cnt, int idx, int p);
    obs_t e;
    e.pwm_en   = run;
    e.busy     = run;
    e.seq_done = done;
    e.count    = 16'(cnt);
    e.idx      = 3'(idx);
    e.cmp1     = mdl_tab[idx].cmp1;
    e.cmp2     = mdl_tab[idx].cmp2;
    e.func     = {6'b0, mdl_tab[idx].func};
    e.period   = 16'(p);
    return e;
  endfunction

  task automatic checkOutput(input string name, input obs_t exp);
    obs_t act;
    act = get_obs();
    checks++;
    if (act === exp) begin
      passed++;
    end else begin
      $display("[TB] FAIL %s @%0t: actual en=%0b busy=%0b done=%0b cnt=%0d idx=%0d c1=%h c2=%h fn=%h per=%0d, expected en=%0b busy=%0b done=%0b cnt=%0d idx=%0d c1=%h c2=%h fn=%h per=%0d",
               name, $time, act.pwm_en, act.busy, act.seq_done, act.count, act.idx, act.cmp1, act.cmp2, act.func, act.period,
               exp.pwm_en, exp.busy, exp.seq_done, exp.count, exp.idx, exp.cmp1, exp.cmp2, exp.func, exp.period);
    end
  endtask

  task automatic applyStimulus(input bit st, input bit sp, input int len, input int p, input bit lp);
    bus.start     = st;
    bus.stop      = sp;
    bus.seq_len   = 4'(len);
    bus.period_in = 16'(p);
    bus.loop_en   = lp;
  endtask

  task automatic cfg_write(input int addr, input ent_t e);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'(addr);
    bus.cfg_wdata = pack(e);
    @(negedge clk);
    bus.cfg_we    = 1'b0;
    mdl_tab[addr] = e;
  endtask

  // Reference model: expand the table into the list of (entry, count) pairs the
  // channel should show, one per cycle, then walk the DUT through it.
  task automatic run_model(input string name, input int p, input int len, input bit lp,
                           input int stop_at, input int wr_at, input int wr_addr, input ent_t wr_ent);
    int q_idx[$];
    int q_cnt[$];
    int e;
    do begin
      for (int i = 0; i < len; i++) begin
        int reps;
        reps = (mdl_tab[i].rep == 8'd0) ? 1 : int'(mdl_tab[i].rep);
        for (int r = 0; r < reps; r++) begin
          for (int c = 0; c <= p; c++) begin
            q_idx.push_back(i);
            q_cnt.push_back(c);
          end
        end
      end
    end while (lp && (q_idx.size() <= stop_at + p + 1));

    if (stop_at >= 0 && stop_at < q_idx.size())
      e = stop_at + p - q_cnt[stop_at];
    else
      e = q_idx.size() - 1;

    applyStimulus(1'b1, 1'b0, len, p, lp);
    for (int k = 0; k <= e + 2; k++) begin
      @(negedge clk);
      bus.start  = 1'b0;
      bus.cfg_we = 1'b0;
      if (k <= e)
        checkOutput(name, mk_exp(1'b1, 1'b0, q_cnt[k], q_idx[k], p));
      else
        checkOutput(name, mk_exp(1'b0, k == e + 1, 0, q_idx[e], p));
      bus.stop = (k == stop_at);
      if (k == wr_at) begin
        bus.cfg_we       = 1'b1;
        bus.cfg_addr     = 3'(wr_addr);
        bus.cfg_wdata    = pack(wr_ent);
        mdl_tab[wr_addr] = wr_ent;
      end
    end
    bus.stop   = 1'b0;
    bus.cfg_we = 1'b0;
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vec_t vecs [13];
    ent_t none;
    ent_t nw;
    none = mk_ent(0, 0, 0, 0);
    for (int i = 0; i < DEPTH; i++) mdl_tab[i] = none;

    rst = 1'b1;
    bus.cfg_we = 1'b0;
    bus.cfg_addr = '0;
    bus.cfg_wdata = '0;
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("reset", '0);
    rst = 1'b0;
    @(negedge clk);

    // Period 0: every cycle is a boundary
    cfg_write(0, mk_ent(10, 16'h100, 1, FUNC_EDGE));
    cfg_write(1, mk_ent(11, 16'h101, 1, FUNC_CENTER));
    cfg_write(2, mk_ent(12, 16'h102, 1, FUNC_DUAL));
    vecs[0]  = '{1, 0, 3, 1, 0, 0};
    vecs[1]  = '{0, 0, 3, 1, 0, 1};
    vecs[2]  = '{0, 0, 3, 1, 0, 2};
    vecs[3]  = '{0, 0, 3, 0, 1, 2};
    vecs[4]  = '{0, 0, 3, 0, 0, 2};
    vecs[5]  = '{1, 0, 0, 0, 0, 2};
    vecs[6]  = '{1, 0, 9, 0, 0, 2};
    vecs[7]  = '{1, 0, 1, 1, 0, 0};
    vecs[8]  = '{0, 0, 1, 0, 1, 0};
    vecs[9]  = '{0, 1, 1, 0, 0, 0};
    vecs[10] = '{1, 1, 2, 1, 0, 0};
    vecs[11] = '{0, 0, 2, 1, 0, 1};
    vecs[12] = '{0, 0, 2, 0, 1, 1};
    for (int i = 0; i < 13; i++) begin
      applyStimulus(vecs[i].start, vecs[i].stop, vecs[i].len, 0, 1'b0);
      @(negedge clk);
      checkOutput($sformatf("vec%0d", i), mk_exp(vecs[i].exp_run, vecs[i].exp_done, 0, vecs[i].exp_idx, 0));
    end
    applyStimulus(1'b0, 1'b0, 0, 0, 1'b0);

    // Two-entry one-shot, then looping with a stop mid-entry-1
    cfg_write(0, mk_ent(3, 16'h0A0, 2, FUNC_CENTER));
    cfg_write(1, mk_ent(7, 16'h0B0, 1, FUNC_DUAL));
    run_model("oneshot", 9, 2, 1'b0, -1, -1, 0, none);
    run_model("loop_stop", 9, 2, 1'b1, 54, -1, 0, none);

    // Reset in the middle of a run clears everything, including the table
    applyStimulus(1'b1, 1'b0, 2, 9, 1'b0);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      bus.start = 1'b0;
      checkOutput("pre_reset", mk_exp(1'b1, 1'b0, k, 0, 9));
    end
    rst = 1'b1;
    @(negedge clk);
    checkOutput("reset_mid_run", '0);
    rst = 1'b0;
    for (int i = 0; i < DEPTH; i++) mdl_tab[i] = none;
    @(negedge clk);
    checkOutput("idle_after_reset", '0);
    run_model("after_reset_rep0", 3, 1, 1'b0, -1, -1, 0, none);

    // Write entry 1 while entry 0 is running
    cfg_write(0, mk_ent(3, 16'h11, 1, FUNC_EDGE));
    cfg_write(1, mk_ent(7, 16'h22, 1, FUNC_CENTER));
    run_model("midrun_write", 4, 2, 1'b0, -1, 1, 1, mk_ent(5, 16'h22, 1, FUNC_CENTER));

    // Write and load of entry 0 on the same edge: the load sees old data
    nw = mk_ent(16'h55, 16'h44, 1, FUNC_DUAL);
    applyStimulus(1'b1, 1'b0, 1, 1, 1'b0);
    bus.cfg_we    = 1'b1;
    bus.cfg_addr  = 3'd0;
    bus.cfg_wdata = pack(nw);
    @(negedge clk);
    bus.start  = 1'b0;
    bus.cfg_we = 1'b0;
    checkOutput("same_cycle_old", mk_exp(1'b1, 1'b0, 0, 0, 1));
    @(negedge clk);
    checkOutput("same_cycle_old", mk_exp(1'b1, 1'b0, 1, 0, 1));
    @(negedge clk);
    checkOutput("same_cycle_done", mk_exp(1'b0, 1'b1, 0, 0, 1));
    mdl_tab[0] = nw;
    run_model("reload_new", 1, 1, 1'b0, -1, -1, 0, none);

    // Randomized tables and run parameters
    for (int it = 0; it < 24; it++) begin
      int p, len, stop_at;
      bit lp;
      for (int i = 0; i < DEPTH; i++)
        cfg_write(i, mk_ent($urandom_range(0, 65535), $urandom_range(0, 65535),
                            $urandom_range(0, 3), $urandom_range(0, 2)));
      p   = $urandom_range(0, 5);
      len = $urandom_range(1, DEPTH);
      lp  = 1'($urandom_range(0, 1));
      if (lp)
        stop_at = $urandom_range(0, 60);
      else
        stop_at = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 40) : -1;
      run_model($sformatf("rand%0d", it), p, len, lp, stop_at, -1, 0, none);
    end

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
